// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Byte-serial load/store engine between the control FSM and a byte-wide
//   RAM port. Takes one byte/half/word request at a time, moves it little-
//   endian one byte per clock, then returns sign/zero-extended load data
//   with a single-cycle response pulse.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake (ready only while idle)
//   req_write              1 store, 0 load
//   req_width              0 byte, 1 half, 2 word, 3 reserved (error)
//   req_unsigned           zero-extend loads (LBU/LHU)
//   req_addr, req_wdata    first byte address, store data (low bytes)
//   resp_valid/resp_err    completion pulse and its error qualifier
//   resp_rdata             extended load data, 0 for stores/errors; held
//   busy                   inverse of req_ready
//   mem_addr/mem_we/
//   mem_wdata/mem_rdata    byte RAM port (read data combinational on addr)
module mem_access_unit #(
  parameter int unsigned ADDR_W           = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic                write_q, write_d;
  logic [1:0]          width_q, width_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rbuf_q, rbuf_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;

  logic                req_err;
  logic [1:0]          last_idx;
  logic [31:0]         load_word;

  // Reserved width always fails; alignment only matters when disallowed.
  always_comb begin
    req_err = (req_width == 2'd3) ||
              (!ALLOW_MISALIGNED &&
               ((req_width == 2'd1 && req_addr[0]) ||
                (req_width == 2'd2 && req_addr[1:0] != 2'b00)));
  end

  always_comb begin
    unique case (width_q)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    write_d      = write_q;
    width_d      = width_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    load_word    = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          width_d    = req_width;
          uns_d      = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          byte_cnt_d = '0;
          rbuf_d     = '0;
          if (req_err) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (!write_q) begin
          rbuf_d[{byte_cnt_q, 3'b000} +: 8] = mem_rdata;
        end
        if (byte_cnt_q == last_idx) begin
          // Response is registered on the same edge that captures the last
          // byte, so extension works on the updated buffer, not rbuf_q.
          unique case (width_q)
            2'd0:    load_word = {{24{~uns_q & rbuf_d[7]}},  rbuf_d[7:0]};
            2'd1:    load_word = {{16{~uns_q & rbuf_d[15]}}, rbuf_d[15:0]};
            default: load_word = rbuf_d;
          endcase
          state_d      = DONE;
          byte_cnt_d   = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? '0 : load_word;
        end else begin
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      write_q      <= 1'b0;
      width_q      <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      write_q      <= write_d;
      width_q      <= width_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // RAM port decodes purely from registered state, so reset kills mem_we
  // asynchronously and nothing leaks outside ACCESS.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_addr = addr_q + ADDR_W'(byte_cnt_q);
      mem_we   = write_q;
      if (write_q) begin
        mem_wdata = wdata_q[{byte_cnt_q, 3'b000} +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Bench for mem_access_unit: a byte RAM behind the DUT, a reference byte
//   image plus an arithmetic load model, a vector table, hand-written
//   corner sequences and a randomized request loop. A second instance with
//   misaligned accesses disallowed covers the alignment-error path.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_valid2;
  logic        req_write;
  logic [1:0]  req_width;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready, resp_valid, resp_err, busy, mem_we;
  logic [31:0] resp_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        req_ready2, resp_valid2, resp_err2, busy2, mem_we2;
  logic [31:0] resp_rdata2, mem_addr2;
  logic [7:0]  mem_wdata2, mem_rdata2;

  int n_cmp;
  int n_mis;

  logic [7:0] ram  [logic [31:0]];
  logic [7:0] refm [logic [31:0]];

  mem_access_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .busy(busy), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_al (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid2), .resp_err(resp_err2),
    .resp_rdata(resp_rdata2), .busy(busy2), .mem_addr(mem_addr2),
    .mem_we(mem_we2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  assign mem_rdata2 = 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : 8'h00;
  endfunction

  always @(negedge clk or mem_addr) mem_rdata = ram_rd(mem_addr);

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a]  = b;
    refm[a] = b;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] wd);
    return (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : 4;
  endfunction

  // Load value from the reference image: little-endian sum, then sign
  // extension by subtracting 2**(8N) when the top bit is set.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] wd, input bit u);
    int n;
    logic [63:0] v;
    n = nbytes(wd);
    v = '0;
    for (int i = 0; i < n; i++) v += 64'(ref_rd(a + 32'(i))) << (8 * i);
    if (!u && v[8 * n - 1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic do_req(input bit w, input logic [1:0] wd, input bit u,
                        input logic [31:0] a, input logic [31:0] wdat,
                        input logic [31:0] exp_rd, input bit exp_err,
                        input bit hold, input string name);
    int n;
    int lat;
    n   = nbytes(wd);
    lat = exp_err ? 1 : n + 1;
    @(negedge clk);
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
    req_write = w; req_width = wd; req_unsigned = u;
    req_addr = a; req_wdata = wdat; req_valid = 1'b1;
    @(posedge clk);
    #1;
    // Fields scrambled after acceptance; with hold the bench keeps offering
    // a store to 0x300 that must be ignored while busy.
    req_valid = hold; req_write = 1'b1; req_width = 2'd0;
    req_addr = 32'h300; req_wdata = $urandom; req_unsigned = $urandom_range(0, 1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (!exp_err && c <= n) begin
        chk({name, "_addr"}, mem_addr, a + 32'(c - 1));
        chk({name, "_we"}, 32'(mem_we), 32'(w));
        if (w) chk({name, "_wdata"}, 32'(mem_wdata), 32'(wdat[8 * (c - 1) +: 8]));
      end else begin
        chk({name, "_we_idle"}, 32'(mem_we), 32'd0);
      end
      chk({name, "_busy"}, 32'(busy), (c <= lat) ? 32'd1 : 32'd0);
      if (c == lat) begin
        chk({name, "_valid"}, 32'(resp_valid), 32'd1);
        chk({name, "_err"}, 32'(resp_err), 32'(exp_err));
        chk({name, "_rdata"}, resp_rdata, exp_rd);
        req_valid = 1'b0;
      end else begin
        chk({name, "_novalid"}, 32'(resp_valid), 32'd0);
      end
      if (c == lat + 1) chk({name, "_rdata_hold"}, resp_rdata, exp_rd);
    end
    if (w && !exp_err) begin
      for (int i = 0; i < n; i++) refm[a + 32'(i)] = wdat[8 * i +: 8];
    end
  endtask

  task automatic do_req2(input logic [1:0] wd, input logic [31:0] a,
                         input logic [31:0] exp_rd, input bit exp_err, input string name);
    int n;
    int lat;
    bit we_seen;
    n   = nbytes(wd);
    lat = exp_err ? 1 : n + 1;
    we_seen = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_width = wd; req_unsigned = 1'b0;
    req_addr = a; req_wdata = 32'h0; req_valid2 = 1'b1;
    @(posedge clk);
    #1;
    req_valid2 = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (mem_we2) we_seen = 1'b1;
      if (!exp_err && c <= n) chk({name, "_addr"}, mem_addr2, a + 32'(c - 1));
      chk({name, "_ready"}, 32'(req_ready2), (c <= lat) ? 32'd0 : 32'd1);
      chk({name, "_busy"}, 32'(busy2), (c <= lat) ? 32'd1 : 32'd0);
      if (c == lat) begin
        chk({name, "_valid"}, 32'(resp_valid2), 32'd1);
        chk({name, "_err"}, 32'(resp_err2), 32'(exp_err));
        chk({name, "_rdata"}, resp_rdata2, exp_rd);
      end else begin
        chk({name, "_novalid"}, 32'(resp_valid2), 32'd0);
      end
    end
    chk({name, "_no_we"}, 32'(we_seen), 32'd0);
  endtask

  typedef struct {
    bit          w;
    logic [1:0]  wd;
    bit          u;
    logic [31:0] a;
    logic [31:0] wdat;
    logic [31:0] pre;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          hold;
    string       name;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [7:0] unused_wdata2;

    n_cmp = 0; n_mis = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
    req_width = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h80,       32'h0,        32'h00000058, 32'h00000058, 1'b0, 1'b0, "lw_80"});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h10,       32'h0,        32'h00000080, 32'hFFFFFF80, 1'b0, 1'b0, "lb_10"});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h10,       32'h0,        32'h00000080, 32'h00000080, 1'b0, 1'b1, "lbu_10"});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h20,       32'h0,        32'h0000F234, 32'hFFFFF234, 1'b0, 1'b0, "lh_20"});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h20,       32'h0,        32'h0000F234, 32'h0000F234, 1'b0, 1'b0, "lhu_20"});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h31,       32'h0,        32'h00007F80, 32'h00007F80, 1'b0, 1'b0, "lh_31"});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h79,       32'h1234ABCD, 32'h0,        32'h00000000, 1'b0, 1'b1, "sh_79"});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hDEADBEEF, 32'h0,        32'h00000000, 1'b0, 1'b0, "sw_wrap"});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h100,      32'h0,        32'h0,        32'h00000000, 1'b1, 1'b0, "rsv_ld"});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h104,      32'hFFFFFFFF, 32'h0,        32'h00000000, 1'b1, 1'b0, "rsv_st"});
    tbl.push_back('{1'b0, 2'd2, 1'b1, 32'h83,       32'h0,        32'h84030201, 32'h84030201, 1'b0, 1'b0, "lw_83"});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;

    poke(32'h78, 8'h11);
    poke(32'h7B, 8'h22);
    foreach (tbl[i]) begin
      if (!tbl[i].w) begin
        for (int b = 0; b < nbytes(tbl[i].wd); b++) poke(tbl[i].a + 32'(b), tbl[i].pre[8 * b +: 8]);
      end
      do_req(tbl[i].w, tbl[i].wd, tbl[i].u, tbl[i].a, tbl[i].wdat,
             tbl[i].exp_rd, tbl[i].exp_err, tbl[i].hold, tbl[i].name);
    end
    chk("sh_mem78", 32'(ram_rd(32'h78)), 32'h11);
    chk("sh_mem79", 32'(ram_rd(32'h79)), 32'hCD);
    chk("sh_mem7A", 32'(ram_rd(32'h7A)), 32'hAB);
    chk("sh_mem7B", 32'(ram_rd(32'h7B)), 32'h22);
    chk("sw_memFE", 32'(ram_rd(32'hFFFFFFFE)), 32'hEF);
    chk("sw_memFF", 32'(ram_rd(32'hFFFFFFFF)), 32'hBE);
    chk("sw_mem00", 32'(ram_rd(32'h0)), 32'hAD);
    chk("sw_mem01", 32'(ram_rd(32'h1)), 32'hDE);
    chk("busy_ignored", 32'(ram.exists(32'h300)), 32'd0);

    // Alignment errors on the strict instance
    do_req2(2'd2, 32'h81, 32'h0, 1'b1, "al_lw_81");
    do_req2(2'd1, 32'h79, 32'h0, 1'b1, "al_lh_79");
    do_req2(2'd3, 32'h84, 32'h0, 1'b1, "al_rsv");
    do_req2(2'd2, 32'h84, 32'hA5A5A5A5, 1'b0, "al_lw_84");
    do_req2(2'd1, 32'h82, 32'hFFFFA5A5, 1'b0, "al_lh_82");

    // Reset in the middle of a store: first two bytes land, rest do not
    poke(32'h40, 8'h00); poke(32'h41, 8'h00); poke(32'h42, 8'h55); poke(32'h43, 8'h66);
    @(negedge clk);
    req_write = 1'b1; req_width = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_novalid", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_novalid_after", 32'(resp_valid), 32'd0);
    chk("mid_rst_ready_after", 32'(req_ready), 32'd1);
    chk("mid_rst_m40", 32'(ram_rd(32'h40)), 32'h44);
    chk("mid_rst_m41", 32'(ram_rd(32'h41)), 32'h33);
    chk("mid_rst_m42", 32'(ram_rd(32'h42)), 32'h55);
    chk("mid_rst_m43", 32'(ram_rd(32'h43)), 32'h66);
    refm[32'h40] = 8'h44;
    refm[32'h41] = 8'h33;

    // Randomized traffic against the reference image
    for (int i = 0; i < 20; i++) poke(32'h200 + 32'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      poke(32'hFFFFFFF8 + 32'(i), 8'($urandom));
      poke(32'(i), 8'($urandom));
    end
    for (int it = 0; it < 60; it++) begin
      bit          w, u, e, h;
      logic [1:0]  wd;
      logic [31:0] a, wdat, exp;
      w    = $urandom_range(0, 1);
      u    = $urandom_range(0, 1);
      wd   = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
      a    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 7))
                                         : 32'h200 + 32'($urandom_range(0, 15));
      wdat = $urandom;
      h    = ($urandom_range(0, 3) == 0);
      e    = (wd == 2'd3);
      exp  = (w || e) ? 32'h0 : model_load(a, wd, u);
      do_req(w, wd, u, a, wdat, exp, e, h, "rnd");
    end
    for (int i = 0; i < 20; i++) chk("rnd_mem", 32'(ram_rd(32'h200 + 32'(i))), 32'(ref_rd(32'h200 + 32'(i))));
    for (int i = 0; i < 8; i++) begin
      chk("rnd_mem_hi", 32'(ram_rd(32'hFFFFFFF8 + 32'(i))), 32'(ref_rd(32'hFFFFFFF8 + 32'(i))));
      chk("rnd_mem_lo", 32'(ram_rd(32'(i))), 32'(ref_rd(32'(i))));
    end
    chk("rnd_busy_ignored", 32'(ram.exists(32'h300)), 32'd0);

    unused_wdata2 = mem_wdata2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
